// File: rtl/enc_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : enc_event_fifo
// Description : Captures change-of-code events from a 2-bit priority encoder
//               into a small show-ahead FIFO. An event is a valid code that
//               either follows an idle cycle or differs from the previous
//               code. Events arriving while the FIFO is full (with no pop
//               the same cycle) are dropped and flagged by a sticky overflow.
//               Optional macro ENC_EVENT_OVF_CNT_EN adds an 8-bit saturating
//               dropped-event counter on port ovf_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_event_fifo #(
    parameter int DEPTH = 4                     // 2, 4, 8 or 16 entries
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     q0,
    input  logic                     q1,
    input  logic                     v,
    output logic [1:0]               out_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef ENC_EVENT_OVF_CNT_EN
    ,
    output logic [7:0]               ovf_cnt
`endif
);

    localparam int             c_AW    = $clog2(DEPTH);
    localparam int             c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_AW-1:0] c_LAST  = c_AW'(DEPTH - 1);

    logic [1:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_v_d;
    logic [1:0]      r_code_d;
    logic            r_overflow;

    logic [1:0]      w_code;
    logic            w_event;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_empty;
    logic            w_full;

    assign w_code  = {q1, q0};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // An event needs a valid code that is new relative to the previous cycle.
    assign w_event = v && (!r_v_d || (w_code != r_code_d));
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO can still accept when its head leaves in the same cycle.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && !w_push;

    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign out_valid = !w_empty;
    assign overflow  = r_overflow;
    // Head is forced to zero when empty so stale memory never leaks out.
    assign out_code  = w_empty ? 2'b00 : r_mem[r_rd_ptr];

    // Input history, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v_d      <= 1'b0;
            r_code_d   <= 2'b00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_v_d    <= v;
            r_code_d <= w_code;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_code;
        end
    end

`ifdef ENC_EVENT_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    assign ovf_cnt = r_ovf_cnt;

    // Saturating count of dropped events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= 8'd0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/enc_event_fifo.md
ENC_EVENT_FIFO -- requirements
Module: enc_event_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; legal values 2, 4, 8, 16 only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 q0  input  1  encoder code bit 0, synchronous to clk.
REQ-005 q1  input  1  encoder code bit 1, synchronous to clk.
REQ-006 v  input  1  encoder valid (at least one request line active).
REQ-007 out_code  output  2  code at FIFO head, {q1,q0} order.
REQ-008 out_valid  output  1  head entry present.
REQ-009 out_ready  input  1  consumer accepts head this cycle.
REQ-010 full  output  1  count == DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 overflow  output  1  sticky: an event was dropped.

Function
REQ-014 Block SHALL register v and {q1,q0} each cycle as v_d and code_d, reset to 0.
REQ-015 Event SHALL be detected when v==1 and (v_d==0 or {q1,q0}!=code_d); no event while v==0.
REQ-016 Push SHALL occur on an event when count<DEPTH, or when count==DEPTH and a pop occurs the same cycle.
REQ-017 Pop SHALL occur when out_valid==1 and out_ready==1; out_ready while empty SHALL have no effect.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 FIFO SHALL be show-ahead: out_code equals head entry whenever out_valid==1; out_code SHALL be 2'b00 when empty.
REQ-020 Event sampled at edge N SHALL appear as out_valid==1 after edge N (latency one cycle into an empty FIFO).
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0; entries SHALL pop in push order.
REQ-022 out_valid SHALL equal !empty; full and empty SHALL be derived from count, never both 1.
REQ-023 Event while full without same-cycle pop SHALL be dropped, leave FIFO unchanged, and set overflow to 1.
REQ-024 overflow SHALL stay 1 until reset.
REQ-025 Stable v==1 with unchanged code SHALL produce exactly one event.

Reset
REQ-026 rst_n==0 SHALL immediately force count=0, pointers=0, v_d=0, code_d=0, overflow=0, out_valid=0, empty=1, full=0, out_code=2'b00, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; first edge after release SHALL treat v_d as 0.
REQ-028 Memory contents need not be reset.

Configuration
REQ-029 Macro ENC_EVENT_OVF_CNT_EN, when defined, SHALL add output ovf_cnt (8 bits) counting dropped events, saturating at 255, reset to 0.
REQ-030 Without ENC_EVENT_OVF_CNT_EN, port ovf_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, then v=1 code 2'b11 for 3 cycles, out_ready=0 -> count=1, out_code=2'b11, out_valid=1 one cycle after first sample.
REQ-032 Codes 01,10,11,00 on consecutive cycles with v=1, out_ready=0 -> full=1; then out_ready=1 -> pops 01,10,11,00 in order, then empty=1.
REQ-033 Full FIFO, one more code change, out_ready=0 -> event dropped, overflow=1, count=4; with macro ovf_cnt=1.
REQ-034 Full FIFO, new event with out_ready=1 same cycle -> count stays 4, overflow stays 0, new code at tail.
REQ-035 v toggling 1,0,1 with code 2'b10 constant -> two entries of 2'b10.
REQ-036 Assert rst_n=0 mid-cycle with count=3 -> outputs reset immediately before next clk edge; overflow=0.
